// File: rtl/instr_encoder_if.sv
// Bundle of handshake and field signals for instr_encoder.
// master: producer/consumer side (loader or harness); slave: the encoder itself.
interface instr_encoder_if #(
  parameter int unsigned CNT_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       fmt;
  logic [6:0]       op;
  logic [4:0]       rd;
  logic [4:0]       rs1;
  logic [4:0]       rs2;
  logic [31:0]      imm;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_instr;
  logic [CNT_W-1:0] instr_cnt;
  logic             err;
  logic             err_clr;

  modport master (
    output in_valid, fmt, op, rd, rs1, rs2, imm, out_ready, err_clr,
    input  in_ready, out_valid, out_instr, instr_cnt, err
  );

  modport slave (
    input  in_valid, fmt, op, rd, rs1, rs2, imm, out_ready, err_clr,
    output in_ready, out_valid, out_instr, instr_cnt, err
  );
endinterface

// File: rtl/instr_encoder.sv
// Packs decoded instruction fields into 32-bit words and buffers them in a small FIFO.
// Optional feature macro ENC_RANGE_CHECK_EN: reject I/B immediates that do not fit
// a 15-bit signed field instead of silently truncating them.
module instr_encoder #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 16
) (
  input logic            clk,
  input logic            rst,
  instr_encoder_if.slave bus
);
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  localparam logic [1:0] FMT_R   = 2'd0;
  localparam logic [1:0] FMT_I   = 2'd1;
  localparam logic [1:0] FMT_B   = 2'd2;

  logic [31:0]      mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic [CNT_W-1:0] cnt;
  logic             err_q;

  logic        full;
  logic        accept;
  logic        reject;
  logic        push;
  logic        pop;
  logic        imm_fits;
  logic [31:0] word;

  assign full          = (count == FULL_CNT);
  assign bus.in_ready  = ~full;
  assign bus.out_valid = (count != '0);
  assign bus.out_instr = mem[rd_ptr];
  assign bus.instr_cnt = cnt;
  assign bus.err       = err_q;

  // imm survives 15-bit sign extension only if bits 31..14 are all equal
  assign imm_fits = (&bus.imm[31:14]) | ~(|bus.imm[31:14]);

  assign accept = bus.in_valid & bus.in_ready;
  assign pop    = bus.out_valid & bus.out_ready;

  // Classify the offered bundle as rejected (reserved format or bad immediate)
`ifdef ENC_RANGE_CHECK_EN
  always_comb begin
    reject = 1'b0;
    if (bus.fmt == 2'd3) reject = 1'b1;
    else if ((bus.fmt == FMT_I || bus.fmt == FMT_B) && !imm_fits) reject = 1'b1;
  end
`else
  always_comb begin
    reject = (bus.fmt == 2'd3);
  end
`endif

  assign push = accept & ~reject;

  // Field packing; unused bits stay zero
  always_comb begin
    word = '0;
    case (bus.fmt)
      FMT_R:   word = {bus.op, bus.rd, bus.rs1, bus.rs2, 10'b0};
      FMT_I:   word = {bus.op, bus.rd, bus.rs1, bus.imm[14:0]};
      FMT_B:   word = {bus.op, bus.imm[14:10], bus.rs1, bus.rs2, bus.imm[9:0]};
      default: word = '0;
    endcase
  end

  // FIFO storage; cleared on reset so the head reads zero afterwards
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push) begin
      mem[wr_ptr] <= word;
    end
  end

  // Pointers and occupancy; push+pop together leaves count unchanged
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      count <= count + (AW + 1)'(1);
      else if (pop && !push) count <= count - (AW + 1)'(1);
    end
  end

  // Pushed-word counter, wraps naturally
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       cnt <= '0;
    else if (push) cnt <= cnt + CNT_W'(1);
  end

  // Sticky error; a rejection in the same cycle as a clear keeps it set
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                   err_q <= 1'b0;
    else if (accept && reject) err_q <= 1'b1;
    else if (bus.err_clr)      err_q <= 1'b0;
  end
endmodule

// File: tb/tb_instr_encoder.sv
// Directed self-checking bench for instr_encoder.
module tb_instr_encoder;
  logic clk;
  logic rst;
  int   n_vec;
  int   n_bad;
  int   exp_cnt;

  instr_encoder_if #(.CNT_W(16)) bus ();

  instr_encoder #(.DEPTH(4), .CNT_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [1:0] f, input logic [6:0] o, input logic [4:0] d,
                       input logic [4:0] s1, input logic [4:0] s2, input logic [31:0] im);
    bus.in_valid = 1'b1;
    bus.fmt = f; bus.op = o; bus.rd = d; bus.rs1 = s1; bus.rs2 = s2; bus.imm = im;
  endtask

  // Offer one bundle for exactly one clock edge
  task automatic send(input logic [1:0] f, input logic [6:0] o, input logic [4:0] d,
                      input logic [4:0] s1, input logic [4:0] s2, input logic [31:0] im);
    offer(f, o, d, s1, s2, im);
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic pop_one();
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  initial begin
    n_vec = 0; n_bad = 0; exp_cnt = 0;
    bus.in_valid = 1'b0; bus.fmt = '0; bus.op = '0; bus.rd = '0; bus.rs1 = '0;
    bus.rs2 = '0; bus.imm = '0; bus.out_ready = 1'b0; bus.err_clr = 1'b0;
    rst = 1'b1;
    tick(); tick();
    check_eq("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check_eq("rst_out_instr", bus.out_instr, 32'h0);
    check_eq("rst_cnt", 32'(bus.instr_cnt), 32'd0);
    check_eq("rst_err", 32'(bus.err), 32'd0);
    rst = 1'b0;
    tick();
    check_eq("rst_in_ready", 32'(bus.in_ready), 32'd1);

    // R format, also confirm no same-cycle bypass
    offer(2'd0, 7'h01, 5'd3, 5'd4, 5'd5, 32'h0);
    #1;
    check_eq("no_bypass", 32'(bus.out_valid), 32'd0);
    tick();
    bus.in_valid = 1'b0;
    exp_cnt++;
    check_eq("r_valid", 32'(bus.out_valid), 32'd1);
    check_eq("r_word", bus.out_instr, 32'h02321400);
    check_eq("r_cnt", 32'(bus.instr_cnt), 32'(exp_cnt));
    pop_one();
    check_eq("r_pop_empty", 32'(bus.out_valid), 32'd0);

    // I format, imm = -1
    send(2'd1, 7'h02, 5'd1, 5'd2, 5'd0, 32'hFFFF_FFFF);
    exp_cnt++;
    check_eq("i_word", bus.out_instr, 32'h04117FFF);
    check_eq("i_cnt", 32'(bus.instr_cnt), 32'(exp_cnt));
    pop_one();

    // B format
    send(2'd2, 7'h40, 5'd0, 5'd6, 5'd7, 32'h0000_4C05);
    exp_cnt++;
    check_eq("b_word", bus.out_instr, 32'h81331C05);
    check_eq("b_cnt", 32'(bus.instr_cnt), 32'(exp_cnt));
    pop_one();

    // Reserved format: consumed, nothing pushed, err set
    send(2'd3, 7'h7F, 5'd1, 5'd1, 5'd1, 32'h0);
    check_eq("f3_no_push", 32'(bus.out_valid), 32'd0);
    check_eq("f3_err", 32'(bus.err), 32'd1);
    check_eq("f3_cnt", 32'(bus.instr_cnt), 32'(exp_cnt));
    // Set and clear in the same cycle: set wins
    bus.err_clr = 1'b1;
    send(2'd3, 7'h00, 5'd0, 5'd0, 5'd0, 32'h0);
    check_eq("err_set_wins", 32'(bus.err), 32'd1);
    tick();
    bus.err_clr = 1'b0;
    check_eq("err_clr", 32'(bus.err), 32'd0);

    // Out-of-range immediate
    send(2'd1, 7'h02, 5'd1, 5'd2, 5'd0, 32'd16384);
`ifdef ENC_RANGE_CHECK_EN
    check_eq("range_no_push", 32'(bus.out_valid), 32'd0);
    check_eq("range_err", 32'(bus.err), 32'd1);
    check_eq("range_cnt", 32'(bus.instr_cnt), 32'(exp_cnt));
    bus.err_clr = 1'b1;
    tick();
    bus.err_clr = 1'b0;
`else
    exp_cnt++;
    check_eq("trunc_word", bus.out_instr, 32'h04114000);
    check_eq("trunc_err", 32'(bus.err), 32'd0);
    check_eq("trunc_cnt", 32'(bus.instr_cnt), 32'(exp_cnt));
    pop_one();
`endif

    // In-range boundary immediate, accepted in both builds
    send(2'd1, 7'h02, 5'd1, 5'd2, 5'd0, 32'hFFFF_C000);
    exp_cnt++;
    check_eq("min_imm_word", bus.out_instr, 32'h04114000);
    check_eq("min_imm_cnt", 32'(bus.instr_cnt), 32'(exp_cnt));
    pop_one();

    // Backpressure: fill with op=7'h11, rd=i -> 32'h22000000 | i<<20
    for (int i = 0; i < 4; i++) begin
      send(2'd0, 7'h11, 5'(i), 5'd0, 5'd0, 32'h0);
      exp_cnt++;
    end
    check_eq("full_in_ready", 32'(bus.in_ready), 32'd0);
    check_eq("full_head", bus.out_instr, 32'h22000000);
    // Offer while full and popping: must not be accepted
    offer(2'd0, 7'h11, 5'd9, 5'd0, 5'd0, 32'h0);
    bus.out_ready = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    check_eq("full_no_pass", 32'(bus.instr_cnt), 32'(exp_cnt));
    check_eq("pop_in_ready", 32'(bus.in_ready), 32'd1);
    check_eq("pop_head", bus.out_instr, 32'h22100000);
    // Simultaneous push and pop at occupancy 3
    offer(2'd0, 7'h11, 5'd4, 5'd0, 5'd0, 32'h0);
    bus.out_ready = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    exp_cnt++;
    check_eq("pp_in_ready", 32'(bus.in_ready), 32'd1);
    // Drain remaining 2,3,4 in order
    for (int i = 2; i <= 4; i++) begin
      check_eq("drain_valid", 32'(bus.out_valid), 32'd1);
      check_eq("drain_word", bus.out_instr, 32'h22000000 | (32'(i) << 20));
      tick();
    end
    bus.out_ready = 1'b0;
    check_eq("drain_empty", 32'(bus.out_valid), 32'd0);
    check_eq("drain_cnt", 32'(bus.instr_cnt), 32'(exp_cnt));

    // Async reset with 3 words held and err set
    for (int i = 0; i < 3; i++) send(2'd0, 7'h05, 5'(i), 5'd1, 5'd1, 32'h0);
    send(2'd3, 7'h00, 5'd0, 5'd0, 5'd0, 32'h0);
    check_eq("pre_rst_valid", 32'(bus.out_valid), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check_eq("arst_valid", 32'(bus.out_valid), 32'd0);
    check_eq("arst_cnt", 32'(bus.instr_cnt), 32'd0);
    check_eq("arst_err", 32'(bus.err), 32'd0);
    check_eq("arst_instr", bus.out_instr, 32'h0);
    tick();
    rst = 1'b0;
    tick();
    send(2'd0, 7'h01, 5'd3, 5'd4, 5'd5, 32'h0);
    check_eq("post_rst_word", bus.out_instr, 32'h02321400);
    check_eq("post_rst_cnt", 32'(bus.instr_cnt), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
